// File: rtl/vga_timing_generator.sv
// VGA raster timing: sync pulses, draw strobe and clamped visible coordinates.
// Define VGA_TIMING_FRAME_COUNT_EN to add the 16-bit o_FRAME_COUNT output.
module vga_timing_generator #(
   parameter int   p_H_VISIBLE_AREA  = 640,
   parameter int   p_H_FRONT_PORCH   = 16,
   parameter int   p_H_SYNC_PULSE    = 96,
   parameter int   p_H_BACK_PORCH    = 48,
   parameter int   p_V_VISIBLE_AREA  = 480,
   parameter int   p_V_FRONT_PORCH   = 10,
   parameter int   p_V_SYNC_PULSE    = 2,
   parameter int   p_V_BACK_PORCH    = 33,
   parameter logic p_H_SYNC_POLARITY = 1'b0,
   parameter logic p_V_SYNC_POLARITY = 1'b0
) (
   input  logic i_CLK,
   input  logic i_RESET,
   input  logic i_PIXEL_CE,
   output logic o_VGA_HSYNC,
   output logic o_VGA_VSYNC,
   output logic o_DRAW_ENABLE,
   output logic [$clog2(p_H_VISIBLE_AREA)-1:0] o_SCANLINE_X,
   output logic [$clog2(p_V_VISIBLE_AREA)-1:0] o_SCANLINE_Y,
   output logic o_LINE_START,
   output logic o_FRAME_START
`ifdef VGA_TIMING_FRAME_COUNT_EN
   ,
   output logic [15:0] o_FRAME_COUNT
`endif
);

   localparam int H_TOTAL = p_H_VISIBLE_AREA + p_H_FRONT_PORCH
                          + p_H_SYNC_PULSE + p_H_BACK_PORCH;
   localparam int V_TOTAL = p_V_VISIBLE_AREA + p_V_FRONT_PORCH
                          + p_V_SYNC_PULSE + p_V_BACK_PORCH;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam int XW = $clog2(p_H_VISIBLE_AREA);
   localparam int YW = $clog2(p_V_VISIBLE_AREA);

   localparam logic [HW-1:0] H_VIS_END  = HW'(p_H_VISIBLE_AREA - 1);
   localparam logic [HW-1:0] H_FP_END   = HW'(p_H_VISIBLE_AREA
                                          + p_H_FRONT_PORCH - 1);
   localparam logic [HW-1:0] H_SYNC_END = HW'(p_H_VISIBLE_AREA
                                          + p_H_FRONT_PORCH
                                          + p_H_SYNC_PULSE - 1);
   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);

   localparam logic [VW-1:0] V_VIS_END  = VW'(p_V_VISIBLE_AREA - 1);
   localparam logic [VW-1:0] V_FP_END   = VW'(p_V_VISIBLE_AREA
                                          + p_V_FRONT_PORCH - 1);
   localparam logic [VW-1:0] V_SYNC_END = VW'(p_V_VISIBLE_AREA
                                          + p_V_FRONT_PORCH
                                          + p_V_SYNC_PULSE - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

   typedef enum logic [1:0] {
      H_VISIBLE,
      H_FRONT,
      H_SYNC,
      H_BACK
   } h_state_t;

   typedef enum logic [1:0] {
      V_VISIBLE,
      V_FRONT,
      V_SYNC,
      V_BACK
   } v_state_t;

   h_state_t      h_state, h_state_nxt;
   v_state_t      v_state, v_state_nxt;
   logic [HW-1:0] h_cnt, h_cnt_nxt;
   logic [VW-1:0] v_cnt, v_cnt_nxt;
   logic          h_last;
   logic          v_last;

   always_ff @(posedge i_CLK or posedge i_RESET) begin
      if (i_RESET) begin
         h_state <= H_VISIBLE;
         v_state <= V_VISIBLE;
         h_cnt   <= '0;
         v_cnt   <= '0;
      end else if (i_PIXEL_CE) begin
         h_state <= h_state_nxt;
         v_state <= v_state_nxt;
         h_cnt   <= h_cnt_nxt;
         v_cnt   <= v_cnt_nxt;
      end
   end

   // Phase changes are keyed to the counter value so state never drifts from h/v.
   always_comb begin
      h_last      = (h_cnt == H_LAST);
      v_last      = (v_cnt == V_LAST);
      h_cnt_nxt   = h_last ? '0 : h_cnt + HW'(1);
      v_cnt_nxt   = v_cnt;
      h_state_nxt = h_state;
      v_state_nxt = v_state;

      if (h_last) begin
         v_cnt_nxt = v_last ? '0 : v_cnt + VW'(1);
      end

      unique case (h_state)
         H_VISIBLE: if (h_cnt == H_VIS_END)  h_state_nxt = H_FRONT;
         H_FRONT:   if (h_cnt == H_FP_END)   h_state_nxt = H_SYNC;
         H_SYNC:    if (h_cnt == H_SYNC_END) h_state_nxt = H_BACK;
         H_BACK:    if (h_last)              h_state_nxt = H_VISIBLE;
      endcase

      if (h_last) begin
         unique case (v_state)
            V_VISIBLE: if (v_cnt == V_VIS_END)  v_state_nxt = V_FRONT;
            V_FRONT:   if (v_cnt == V_FP_END)   v_state_nxt = V_SYNC;
            V_SYNC:    if (v_cnt == V_SYNC_END) v_state_nxt = V_BACK;
            V_BACK:    if (v_last)              v_state_nxt = V_VISIBLE;
         endcase
      end
   end

   logic h_vis;
   logic v_vis;

   assign h_vis = (h_state == H_VISIBLE);
   assign v_vis = (v_state == V_VISIBLE);

   // Outputs describe the position consumed by this CE, one cycle later.
   always_ff @(posedge i_CLK or posedge i_RESET) begin
      if (i_RESET) begin
         o_VGA_HSYNC   <= ~p_H_SYNC_POLARITY;
         o_VGA_VSYNC   <= ~p_V_SYNC_POLARITY;
         o_DRAW_ENABLE <= 1'b0;
         o_SCANLINE_X  <= '0;
         o_SCANLINE_Y  <= '0;
         o_LINE_START  <= 1'b0;
         o_FRAME_START <= 1'b0;
      end else if (i_PIXEL_CE) begin
         o_VGA_HSYNC   <= (h_state == H_SYNC) ? p_H_SYNC_POLARITY
                                              : ~p_H_SYNC_POLARITY;
         o_VGA_VSYNC   <= (v_state == V_SYNC) ? p_V_SYNC_POLARITY
                                              : ~p_V_SYNC_POLARITY;
         o_DRAW_ENABLE <= h_vis && v_vis;
         o_SCANLINE_X  <= h_vis ? XW'(h_cnt) : '0;
         o_SCANLINE_Y  <= v_vis ? YW'(v_cnt) : '0;
         o_LINE_START  <= (h_cnt == '0);
         o_FRAME_START <= (h_cnt == '0) && (v_cnt == '0);
      end
   end

`ifdef VGA_TIMING_FRAME_COUNT_EN
   logic [15:0] frame_cnt;

   always_ff @(posedge i_CLK or posedge i_RESET) begin
      if (i_RESET) begin
         frame_cnt <= '0;
      end else if (i_PIXEL_CE && h_last && v_last) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end

   assign o_FRAME_COUNT = frame_cnt;
`endif

endmodule
